tag_lookup_16: RTL and testbench

TAG_LOOKUP_16 -- requirements
Module: tag_lookup_16

---
 rtl/tag_lookup_16.sv | 147 ++++++++++++++
 tb/tb_tag_lookup_16.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_16.sv
// tag_lookup_16: 16-entry fully associative tag store with lowest-index hit
// reporting, single-outstanding miss refill, round-robin replacement and a
// sequential invalidate-all. TAG_BUS exposes every stored tag to a downstream
// 16:1 mux selected by HIT_INDEX.
module tag_lookup_16 #(
    parameter int TAG_W = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lookup_valid,
    input  logic [TAG_W-1:0]     lookup_tag,
    input  logic                 flush,
    input  logic                 miss_ack,
    output logic                 resp_valid,
    output logic                 hit,
    output logic [3:0]           hit_index,
    output logic [16*TAG_W-1:0]  tag_bus,
    output logic                 miss_req,
    output logic [TAG_W-1:0]     miss_tag,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MISS,
        S_FLUSH
    } state_t;

    state_t           state;
    logic [TAG_W-1:0] tags [16];
    logic [15:0]      valid;
    logic [3:0]       repl_ptr;
    logic [3:0]       flush_cnt;

    logic             match_found;
    logic [3:0]       match_idx;
    logic             inv_found;
    logic [3:0]       inv_idx;
    logic [3:0]       victim;

    // Parallel compare of the requested tag against every valid entry; the
    // descending scan leaves the lowest matching index as the winner.
    always_comb begin
        match_found = 1'b0;
        match_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (valid[i] && (tags[i] == lookup_tag)) begin
                match_found = 1'b1;
                match_idx   = 4'(i);
            end
        end
    end

    // Victim selection: a free slot is always preferred over evicting, and
    // only when every slot is occupied does the round-robin pointer decide.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = 4'(i);
            end
        end
        victim = inv_found ? inv_idx : repl_ptr;
    end

    // Flatten the tag registers onto the mux input bus, entry 0 in the low bits.
    always_comb begin
        tag_bus = '0;
        for (int i = 0; i < 16; i++) begin
            tag_bus[TAG_W*i +: TAG_W] = tags[i];
        end
    end

    // Control FSM together with the storage it owns; every output is a
    // register so the downstream mux select never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            valid      <= '0;
            for (int i = 0; i < 16; i++) begin
                tags[i] <= '0;
            end
            repl_ptr   <= 4'd0;
            flush_cnt  <= 4'd0;
            miss_tag   <= '0;
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            hit_index  <= 4'd0;
            miss_req   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        state     <= S_FLUSH;
                        busy      <= 1'b1;
                        flush_cnt <= 4'd0;
                    end else if (lookup_valid) begin
                        resp_valid <= 1'b1;
                        hit        <= match_found;
                        hit_index  <= match_found ? match_idx : 4'd0;
                        if (!match_found) begin
                            miss_tag <= lookup_tag;
                            miss_req <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (miss_ack) begin
                        tags[victim]  <= miss_tag;
                        valid[victim] <= 1'b1;
                        resp_valid    <= 1'b1;
                        hit           <= 1'b1;
                        hit_index     <= victim;
                        miss_req      <= 1'b0;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                        if (!inv_found) begin
                            repl_ptr <= repl_ptr + 4'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    valid[flush_cnt] <= 1'b0;
                    flush_cnt        <= flush_cnt + 4'd1;
                    if (flush_cnt == 4'd15) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        repl_ptr  <= 4'd0;
                        flush_cnt <= 4'd0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    miss_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_16.sv
// tb_tag_lookup_16: directed vector table for fills, hits and evictions, plus
// hand-written sequences for flush, ignored requests and reset during a miss.
module tb_tag_lookup_16;

    localparam int TAG_W = 28;

    logic                 clk;
    logic                 reset;
    logic                 lookup_valid;
    logic [TAG_W-1:0]     lookup_tag;
    logic                 flush;
    logic                 miss_ack;
    logic                 resp_valid;
    logic                 hit;
    logic [3:0]           hit_index;
    logic [16*TAG_W-1:0]  tag_bus;
    logic                 miss_req;
    logic [TAG_W-1:0]     miss_tag;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             expHit;
        logic [3:0]       expIdx;
    } vec_t;

    vec_t vecs [23];

    tag_lookup_16 #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .lookup_tag   (lookup_tag),
        .flush        (flush),
        .miss_ack     (miss_ack),
        .resp_valid   (resp_valid),
        .hit          (hit),
        .hit_index    (hit_index),
        .tag_bus      (tag_bus),
        .miss_req     (miss_req),
        .miss_tag     (miss_tag),
        .busy         (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and log any failure.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one lookup; on a miss, poke ignored requests, acknowledge the
    // refill and check the filled entry and the bus contents.
    task automatic applyStimulus(input string name, input logic [TAG_W-1:0] tag,
                                 input logic expHit, input logic [3:0] expIdx);
        logic [TAG_W-1:0] slot;
        lookup_valid = 1'b1;
        lookup_tag   = tag;
        step();
        lookup_valid = 1'b0;
        checkOutput({name, ".resp_valid"}, resp_valid, 1);
        checkOutput({name, ".hit"}, hit, expHit);
        checkOutput({name, ".hit_index"}, hit_index, expHit ? expIdx : 4'd0);
        checkOutput({name, ".miss_req"}, miss_req, !expHit);
        checkOutput({name, ".busy"}, busy, !expHit);
        if (!expHit) begin
            checkOutput({name, ".miss_tag"}, miss_tag, tag);
            lookup_valid = 1'b1;
            lookup_tag   = ~tag;
            flush        = 1'b1;
            step();
            lookup_valid = 1'b0;
            flush        = 1'b0;
            checkOutput({name, ".ignored_resp"}, resp_valid, 0);
            checkOutput({name, ".miss_req_hold"}, miss_req, 1);
            checkOutput({name, ".miss_tag_hold"}, miss_tag, tag);
            miss_ack = 1'b1;
            step();
            miss_ack = 1'b0;
            checkOutput({name, ".fill_resp"}, resp_valid, 1);
            checkOutput({name, ".fill_hit"}, hit, 1);
            checkOutput({name, ".fill_idx"}, hit_index, expIdx);
            checkOutput({name, ".fill_miss_req"}, miss_req, 0);
            checkOutput({name, ".fill_busy"}, busy, 0);
            slot = tag_bus[expIdx*TAG_W +: TAG_W];
            checkOutput({name, ".tag_bus"}, slot, tag);
        end
        step();
        checkOutput({name, ".pulse_end"}, resp_valid, 0);
    endtask

    initial begin
        int busyCycles;
        int k;
        reset        = 1'b0;
        lookup_valid = 1'b0;
        lookup_tag   = '0;
        flush        = 1'b0;
        miss_ack     = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].tag    = 28'h1234567 + 28'(i * 28'h0010001);
            vecs[i].expHit = 1'b0;
            vecs[i].expIdx = 4'(i);
        end
        vecs[16] = '{28'h1234567 + 28'(9 * 28'h0010001), 1'b1, 4'd9};
        vecs[17] = '{28'hA000000, 1'b0, 4'd0};
        vecs[18] = '{28'hA000001, 1'b0, 4'd1};
        vecs[19] = '{28'h1234567 + 28'(2 * 28'h0010001), 1'b1, 4'd2};
        vecs[20] = '{28'h1234567, 1'b0, 4'd2};
        vecs[21] = '{28'hA000000, 1'b1, 4'd0};
        vecs[22] = '{28'h1234567, 1'b1, 4'd2};

        #12;
        checkOutput("rst.resp_valid", resp_valid, 0);
        checkOutput("rst.hit", hit, 0);
        checkOutput("rst.hit_index", hit_index, 0);
        checkOutput("rst.miss_req", miss_req, 0);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.miss_tag", miss_tag, 0);
        checkOutput("rst.tag_bus", 32'(tag_bus == '0), 1);
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 23; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].tag, vecs[i].expHit, vecs[i].expIdx);
        end
        checkOutput("bus0", tag_bus[TAG_W-1:0], 28'hA000000);

        for (int j = 0; j < 14; j++) begin
            applyStimulus($sformatf("wrap%0d", j), 28'hB000000 + 28'(j), 1'b0, 4'((3 + j) % 16));
        end

        miss_ack = 1'b1;
        step();
        miss_ack = 1'b0;
        checkOutput("stray_ack.resp", resp_valid, 0);
        checkOutput("stray_ack.busy", busy, 0);

        flush        = 1'b1;
        lookup_valid = 1'b1;
        lookup_tag   = 28'hB00000C;
        step();
        flush        = 1'b0;
        lookup_valid = 1'b0;
        checkOutput("flush.no_resp", resp_valid, 0);
        checkOutput("flush.busy", busy, 1);
        busyCycles = 0;
        k = 0;
        while (busy && k < 40) begin
            busyCycles++;
            lookup_valid = k[0];
            lookup_tag   = 28'hB00000C;
            if (resp_valid) begin
                checkOutput("flush.stray_resp", resp_valid, 0);
            end
            step();
            k++;
        end
        lookup_valid = 1'b0;
        checkOutput("flush.busy_cycles", busyCycles, 16);
        checkOutput("flush.after_resp", resp_valid, 0);
        step();

        applyStimulus("post_flush0", 28'hB00000C, 1'b0, 4'd0);
        applyStimulus("post_flush1", 28'hB00000B, 1'b0, 4'd1);
        applyStimulus("post_flush_hit", 28'hB00000C, 1'b1, 4'd0);

        lookup_valid = 1'b1;
        lookup_tag   = 28'hC0FFEE0;
        step();
        lookup_valid = 1'b0;
        checkOutput("rstmiss.miss_req", miss_req, 1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rstmiss.miss_req_drop", miss_req, 0);
        checkOutput("rstmiss.busy_drop", busy, 0);
        checkOutput("rstmiss.bus_clear", 32'(tag_bus == '0), 1);
        step();
        reset    = 1'b1;
        miss_ack = 1'b1;
        step();
        miss_ack = 1'b0;
        checkOutput("rstmiss.ack_ignored", resp_valid, 0);
        checkOutput("rstmiss.bus_still_clear", 32'(tag_bus == '0), 1);
        applyStimulus("rstmiss.relookup", 28'hC0FFEE0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
